// File: rtl/noc_switch_rr_pkg.sv
// Shared constants and types for the round-robin wormhole NoC switch.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package noc_switch_pkg;

    // Port numbering used by the 5-port mesh router
    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_S = 3;
    localparam int PORT_W = 4;

    localparam int N_PORTS_DEF = 5;
    localparam int SEL_W       = $clog2(N_PORTS_DEF);

    // Per-output allocation state: free for a new head, or held by a packet
    typedef enum logic {
        SW_IDLE   = 1'b0,
        SW_LOCKED = 1'b1
    } sw_state_t;

    // Round-robin successor of a winning port index
    function automatic int rr_next(input int w, input int n);
        return (w + 1 >= n) ? 0 : w + 1;
    endfunction

endpackage

// File: rtl/noc_switch_rr_if.sv
// Flit bus between the input buffers, the switch and the output controllers.
// Latency: n/a (wires only).
// Backpressure: out_full per output from the controllers, in_grant per input back upstream.
interface noc_switch_rr_if #(
    parameter int N_PORTS    = 5,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_W      = $clog2(N_PORTS)
);
    logic [N_PORTS*DATA_WIDTH-1:0] in_data;
    logic [N_PORTS-1:0]            in_valid;
    logic [N_PORTS*SEL_W-1:0]      in_dest;
    logic [N_PORTS-1:0]            in_tail;
    logic [N_PORTS-1:0]            in_grant;
    logic [N_PORTS*DATA_WIDTH-1:0] out_data;
    logic [N_PORTS-1:0]            out_valid;
    logic [N_PORTS-1:0]            out_full;

    // Upstream buffers and downstream controllers drive the switch
    modport master (
        output in_data, in_valid, in_dest, in_tail, out_full,
        input  in_grant, out_data, out_valid
    );

    // The switch itself
    modport slave (
        input  in_data, in_valid, in_dest, in_tail, out_full,
        output in_grant, out_data, out_valid
    );
endinterface

// File: rtl/noc_switch_rr_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with output readiness.
module rr_arbiter #(
    parameter int N     = 5,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    // Scan from the pointer position and keep the first request seen
    always_comb begin
        int idx;
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                winner   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/noc_switch_rr.sv
// N x N wormhole crossbar with a round-robin allocator per output; SWITCH_OUT_REG_EN registers outputs.
// Latency: grant and flit in the same cycle; with SWITCH_OUT_REG_EN the flit appears one cycle later.
// Backpressure: out_full[o] blocks transfers to o and suppresses the requester's in_grant.
module noc_switch_rr #(
    parameter int N_PORTS    = 5,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_W      = $clog2(N_PORTS)
) (
    input  logic           clk,
    input  logic           rst,
    noc_switch_rr_if.slave sw
);
    import noc_switch_pkg::*;

    logic [N_PORTS*DATA_WIDTH-1:0] in_data;
    logic [N_PORTS-1:0]            in_valid;
    logic [N_PORTS*SEL_W-1:0]      in_dest;
    logic [N_PORTS-1:0]            in_tail;
    logic [N_PORTS-1:0]            out_full;

    assign in_data  = sw.in_data;
    assign in_valid = sw.in_valid;
    assign in_dest  = sw.in_dest;
    assign in_tail  = sw.in_tail;
    assign out_full = sw.out_full;

    sw_state_t        state [N_PORTS];
    logic [SEL_W-1:0] owner [N_PORTS];
    logic [SEL_W-1:0] ptr   [N_PORTS];

    logic [N_PORTS-1:0] locked_in;
    logic [N_PORTS-1:0] req      [N_PORTS];
    logic [N_PORTS-1:0] arb_gnt  [N_PORTS];
    logic [SEL_W-1:0]   arb_win  [N_PORTS];
    logic [N_PORTS-1:0] arb_any;
    logic [N_PORTS-1:0] xfer;
    logic [SEL_W-1:0]   sel      [N_PORTS];
    logic [N_PORTS-1:0] gnt_mask [N_PORTS];
    logic [N_PORTS-1:0] grant_c;
    logic [N_PORTS-1:0] sel_tail;

    logic [N_PORTS*DATA_WIDTH-1:0] out_data_c;
    logic [N_PORTS-1:0]            out_valid_c;

    // Inputs currently mid-packet on some output may not compete for another
    always_comb begin
        locked_in = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            if (state[o] == SW_LOCKED) begin
                locked_in[owner[o]] = 1'b1;
            end
        end
    end

    // Head-flit requests per output; out-of-range destinations match nothing
    always_comb begin
        for (int o = 0; o < N_PORTS; o++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                req[o][i] = in_valid[i] && !locked_in[i] &&
                            (in_dest[i*SEL_W +: SEL_W] == SEL_W'(o));
            end
        end
    end

    for (genvar g = 0; g < N_PORTS; g++) begin : g_arb
        rr_arbiter #(
            .N     (N_PORTS),
            .SEL_W (SEL_W)
        ) u_arb (
            .req    (req[g]),
            .ptr    (ptr[g]),
            .gnt    (arb_gnt[g]),
            .winner (arb_win[g]),
            .any    (arb_any[g])
        );
    end

    // Decide per output whether a flit moves and from which input; reset silences everything
    always_comb begin
        grant_c  = '0;
        sel_tail = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            xfer[o]     = 1'b0;
            sel[o]      = arb_win[o];
            gnt_mask[o] = '0;
            if (!rst) begin
                if (state[o] == SW_LOCKED) begin
                    sel[o]  = owner[o];
                    xfer[o] = in_valid[owner[o]] && !out_full[o];
                    if (xfer[o]) begin
                        gnt_mask[o][owner[o]] = 1'b1;
                    end
                end else begin
                    xfer[o] = arb_any[o] && !out_full[o];
                    if (xfer[o]) begin
                        gnt_mask[o] = arb_gnt[o];
                    end
                end
            end
            sel_tail[o] = in_tail[sel[o]];
            grant_c     = grant_c | gnt_mask[o];
        end
    end

    assign sw.in_grant = grant_c;

    // Lock on a non-tail head, release on the tail, advance the pointer only on new heads
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < N_PORTS; o++) begin
                state[o] <= SW_IDLE;
                owner[o] <= '0;
                ptr[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < N_PORTS; o++) begin
                if (xfer[o]) begin
                    if (state[o] == SW_IDLE) begin
                        ptr[o] <= SEL_W'(rr_next(int'(arb_win[o]), N_PORTS));
                        if (!sel_tail[o]) begin
                            state[o] <= SW_LOCKED;
                            owner[o] <= arb_win[o];
                        end
                    end else if (sel_tail[o]) begin
                        state[o] <= SW_IDLE;
                    end
                end
            end
        end
    end

    // Crossbar: each output muxes its selected input, zero when nothing moves
    always_comb begin
        out_data_c  = '0;
        out_valid_c = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            out_valid_c[o] = xfer[o];
            if (xfer[o]) begin
                out_data_c[o*DATA_WIDTH +: DATA_WIDTH] =
                    in_data[int'(sel[o])*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef SWITCH_OUT_REG_EN
    logic [N_PORTS*DATA_WIDTH-1:0] out_data_q;
    logic [N_PORTS-1:0]            out_valid_q;

    // Output stage: one-cycle pipeline of the crossbar result
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= '0;
        end else begin
            out_data_q  <= out_data_c;
            out_valid_q <= out_valid_c;
        end
    end

    assign sw.out_data  = out_data_q;
    assign sw.out_valid = out_valid_q;
`else
    assign sw.out_data  = out_data_c;
    assign sw.out_valid = out_valid_c;
`endif

endmodule

// File: tb/tb_noc_switch_rr.sv
// Testbench for noc_switch_rr: directed table, corner sequences, randomized run against a reference model.
// Latency: follows SWITCH_OUT_REG_EN (outputs same cycle or one cycle after grant).
// Backpressure: out_full driven by the bench, both directed and random.
module tb_noc_switch_rr;

    localparam int NP = 5;
    localparam int DW = 8;
    localparam int SW = 3;
`ifdef SWITCH_OUT_REG_EN
    localparam bit REG_MODE = 1'b1;
`else
    localparam bit REG_MODE = 1'b0;
`endif
    localparam logic [NP*DW-1:0] DATA_FIX = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_switch_rr_if #(.N_PORTS(NP), .DATA_WIDTH(DW), .SEL_W(SW)) bus ();

    noc_switch_rr #(.N_PORTS(NP), .DATA_WIDTH(DW), .SEL_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [NP-1:0]    v;
        logic [NP*SW-1:0] d;
        logic [NP-1:0]    f;
        logic [NP-1:0]    g;
        logic [NP-1:0]    ov;
        logic [NP*DW-1:0] od;
    } vec_t;

    vec_t tbl[8];

    // reference model: owner per output (-1 = free) and round-robin pointer
    int m_own[NP];
    int m_ptr[NP];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [NP*SW-1:0] pk(input int d0, input int d1, input int d2,
                                             input int d3, input int d4);
        return {SW'(d4), SW'(d3), SW'(d2), SW'(d1), SW'(d0)};
    endfunction

    task automatic drive(input logic [NP-1:0] v, input logic [NP*SW-1:0] d,
                         input logic [NP-1:0] t, input logic [NP-1:0] f);
        bus.in_valid = v;
        bus.in_dest  = d;
        bus.in_tail  = t;
        bus.out_full = f;
        bus.in_data  = DATA_FIX;
    endtask

    task automatic idle();
        drive('0, '0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    task automatic expect_grant(input string nm, input logic [NP-1:0] e);
        @(negedge clk);
        chk(nm, 64'(bus.in_grant), 64'(e));
    endtask

    initial begin
        logic [NP-1:0] rot[6];
        logic [NP-1:0] v, t, f, eg, eov, pov;
        logic [NP*SW-1:0] d;
        logic [NP*DW-1:0] dat, eod, pod;
        int nown[NP], nptr[NP];
        bit r;

        tbl[0] = '{5'b00001, pk(2,0,0,0,0), 5'b00000, 5'b00001, 5'b00100, {8'h00,8'h00,8'hA0,8'h00,8'h00}};
        tbl[1] = '{5'b11010, pk(0,2,0,2,2), 5'b00000, 5'b00010, 5'b00100, {8'h00,8'h00,8'hA1,8'h00,8'h00}};
        tbl[2] = '{5'b00101, pk(1,0,3,0,0), 5'b00000, 5'b00101, 5'b01010, {8'h00,8'hA2,8'h00,8'hA0,8'h00}};
        tbl[3] = '{5'b00010, pk(0,7,0,0,0), 5'b00000, 5'b00000, 5'b00000, 40'h0};
        tbl[4] = '{5'b00001, pk(2,0,0,0,0), 5'b00100, 5'b00000, 5'b00000, 40'h0};
        tbl[5] = '{5'b01000, pk(0,0,0,3,0), 5'b00000, 5'b01000, 5'b01000, {8'h00,8'hA3,8'h00,8'h00,8'h00}};
        tbl[6] = '{5'b11111, pk(4,4,4,4,4), 5'b00000, 5'b00001, 5'b10000, {8'hA0,8'h00,8'h00,8'h00,8'h00}};
        tbl[7] = '{5'b01011, pk(2,2,0,4,0), 5'b00100, 5'b01000, 5'b10000, {8'hA3,8'h00,8'h00,8'h00,8'h00}};

        // reset with active requests: nothing granted, outputs quiet
        rst = 1'b1;
        drive(5'b11111, pk(2,2,2,2,2), 5'b11111, 5'b00000);
        step();
        @(negedge clk);
        chk("rst_grant", 64'(bus.in_grant), 64'h0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_out_data", 64'(bus.out_data), 64'h0);
        rst = 1'b0;

        // single-flit vectors, each from a fresh reset (all pointers at 0)
        for (int i = 0; i < 8; i++) begin
            do_reset();
            drive(tbl[i].v, tbl[i].d, 5'b11111, tbl[i].f);
            @(negedge clk);
            chk($sformatf("vec%0d_grant", i), 64'(bus.in_grant), 64'(tbl[i].g));
`ifdef SWITCH_OUT_REG_EN
            step();
            idle();
            @(negedge clk);
`endif
            chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].ov));
            chk($sformatf("vec%0d_out_data", i), 64'(bus.out_data), 64'(tbl[i].od));
            step();
        end

        // N, S, W contend for E with single-flit packets: grants rotate
        do_reset();
        rot = '{5'b00010, 5'b01000, 5'b10000, 5'b00010, 5'b01000, 5'b10000};
        drive(5'b11010, pk(0,2,0,2,2), 5'b11111, 5'b00000);
        for (int k = 0; k < 6; k++) begin
            expect_grant($sformatf("rotate_c%0d", k), rot[k]);
            step();
        end

        // 4-flit packet N->E holds E against S until after the tail
        do_reset();
        drive(5'b00010, pk(0,2,0,0,0), 5'b00000, 5'b00000);
        expect_grant("pkt_head", 5'b00010);
        step();
        drive(5'b01010, pk(0,0,0,2,0), 5'b00000, 5'b00000);
        expect_grant("pkt_body1", 5'b00010);
        step();
        expect_grant("pkt_body2", 5'b00010);
        step();
        drive(5'b01010, pk(0,0,0,2,0), 5'b00010, 5'b00000);
        expect_grant("pkt_tail", 5'b00010);
        step();
        drive(5'b01000, pk(0,0,0,2,0), 5'b00000, 5'b00000);
        expect_grant("pkt_next_s", 5'b01000);
        step();

        // E full for three cycles mid-packet: lock held, resumes on release
        do_reset();
        drive(5'b00010, pk(0,2,0,0,0), 5'b00000, 5'b00000);
        expect_grant("full_head", 5'b00010);
        step();
        drive(5'b01010, pk(0,0,0,2,0), 5'b00000, 5'b00100);
        for (int k = 1; k <= 3; k++) begin
            expect_grant($sformatf("full_c%0d_grant", k), 5'b00000);
            chk($sformatf("full_c%0d_out_valid", k), 64'(bus.out_valid),
                64'((REG_MODE && k == 1) ? 5'b00100 : 5'b00000));
            step();
        end
        drive(5'b01010, pk(0,0,0,2,0), 5'b00000, 5'b00000);
        expect_grant("full_resume", 5'b00010);
        step();
        drive(5'b01010, pk(0,0,0,2,0), 5'b00010, 5'b00000);
        expect_grant("full_tail", 5'b00010);
        step();
        drive(5'b01000, pk(0,0,0,2,0), 5'b00000, 5'b00000);
        expect_grant("full_then_s", 5'b01000);
        step();

        // reset while E is locked to W drops the lock
        do_reset();
        drive(5'b10000, pk(0,0,0,0,2), 5'b00000, 5'b00000);
        expect_grant("lockw_head", 5'b10000);
        step();
        drive(5'b10010, pk(0,2,0,0,2), 5'b00010, 5'b00000);
        expect_grant("lockw_body", 5'b10000);
        step();
        rst = 1'b1;
        expect_grant("lockw_in_rst", 5'b00000);
        step();
        rst = 1'b0;
        expect_grant("lockw_after_rst", 5'b00010);
        chk("lockw_after_rst_out_valid", 64'(bus.out_valid),
            64'(REG_MODE ? 5'b00000 : 5'b00100));
        step();

        // randomized traffic against the reference model
        do_reset();
        for (int o = 0; o < NP; o++) begin
            m_own[o] = -1;
            m_ptr[o] = 0;
        end
        pov = '0;
        pod = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = ($urandom_range(0, 99) == 0);
            v = NP'($urandom);
            for (int i = 0; i < NP; i++) begin
                d[i*SW +: SW] = SW'($urandom_range(0, 6));
                t[i] = ($urandom_range(0, 9) < 4);
                f[i] = ($urandom_range(0, 9) < 2);
            end
            dat = {8'($urandom), 32'($urandom)};
            rst = r;
            bus.in_valid = v;
            bus.in_dest  = d;
            bus.in_tail  = t;
            bus.out_full = f;
            bus.in_data  = dat;

            eg  = '0;
            eov = '0;
            eod = '0;
            for (int o = 0; o < NP; o++) begin
                nown[o] = m_own[o];
                nptr[o] = m_ptr[o];
            end
            if (!r) begin
                for (int o = 0; o < NP; o++) begin
                    int w;
                    w = -1;
                    if (m_own[o] >= 0) begin
                        if (v[m_own[o]] && !f[o]) w = m_own[o];
                    end else if (!f[o]) begin
                        for (int k = 0; k < NP; k++) begin
                            int i;
                            bool_busy: begin
                                bit busy;
                                i = (m_ptr[o] + k) % NP;
                                busy = 1'b0;
                                for (int q = 0; q < NP; q++) begin
                                    if (m_own[q] == i) busy = 1'b1;
                                end
                                if (w < 0 && v[i] && !busy && int'(d[i*SW +: SW]) == o) w = i;
                            end
                        end
                    end
                    if (w >= 0) begin
                        eg[w]  = 1'b1;
                        eov[o] = 1'b1;
                        eod[o*DW +: DW] = dat[w*DW +: DW];
                        if (m_own[o] < 0) begin
                            nptr[o] = (w + 1) % NP;
                            if (!t[w]) nown[o] = w;
                        end else if (t[w]) begin
                            nown[o] = -1;
                        end
                    end
                end
            end

            @(negedge clk);
            chk($sformatf("rand%0d_grant", cyc), 64'(bus.in_grant), 64'(eg));
            chk($sformatf("rand%0d_out_valid", cyc), 64'(bus.out_valid),
                64'(REG_MODE ? pov : eov));
            chk($sformatf("rand%0d_out_data", cyc), 64'(bus.out_data),
                64'(REG_MODE ? pod : eod));
            pov = eov;
            pod = eod;
            step();
            for (int o = 0; o < NP; o++) begin
                m_own[o] = r ? -1 : nown[o];
                m_ptr[o] = r ? 0 : nptr[o];
            end
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
